// File: rtl/sprite_pkg.sv
// sprite_pkg: shared colour type, fixed palette colours and default parameters
package sprite_pkg;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;
   localparam rgb_t SKY     = '{r: 8'h0A, g: 8'hB1, b: 8'hFF};
   localparam rgb_t MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
   localparam int DEF_SHEET_W        = 200;
   localparam int DEF_TILE           = 40;
   localparam int DEF_ADDR_W         = 16;
   localparam int DEF_PIX_W          = 4;
   localparam int DEF_NUM_SPR        = 2;
   localparam int DEF_PAL_DEPTH      = 16;
   localparam int DEF_TRANSPARENT_ID = 0;
   localparam int DEF_COLOR_W        = 8;
   localparam int DEF_ORIGIN_X       = 120;
   localparam int DEF_ORIGIN_Y       = 40;
endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: sprite-sheet address from tile-relative coordinates
//   rx, ry         : 16-bit coordinates relative to the sprite/tile origin
//   tile_x, tile_y : sheet tile column/row
//   flip           : horizontal mirror within the tile
//   addr           : sheet pixel address, truncated to ADDR_W
module sprite_addr_gen import sprite_pkg::*; #(
   parameter int SHEET_W = DEF_SHEET_W,
   parameter int TILE    = DEF_TILE,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic [15:0]       rx,
   input  logic [15:0]       ry,
   input  logic [2:0]        tile_x,
   input  logic [2:0]        tile_y,
   input  logic              flip,
   output logic [ADDR_W-1:0] addr
);
   logic [15:0] mx, my, fx;
   always_comb begin
      mx = rx % 16'(TILE);
      my = ry % 16'(TILE);
      fx = flip ? 16'(TILE - 1) - mx : mx;
      addr = ADDR_W'(32'(SHEET_W * TILE) * 32'(tile_y) + 32'(TILE) * 32'(tile_x)
                     + 32'(fx) + 32'(my) * 32'(SHEET_W));
   end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: 3-stage sprite/background compositor with writable palette
//   Clk, Reset_n            : clock, asynchronous active-low reset
//   pix_valid, DrawX, DrawY : current screen pixel
//   spr_*                   : per-layer hit, position, sheet tile and flip (layer 0 wins)
//   bg_tile_x, bg_tile_y    : background tile for this pixel
//   rom_addr_*, rom_data_*  : external synchronous ROMs, 1-cycle read latency
//   pal_we/waddr/wdata      : palette write port, wdata = {R,G,B}
//   out_valid, VGA_R/G/B    : registered output pixel, 3 cycles after input
module sprite_compositor import sprite_pkg::*; #(
   parameter int SHEET_W        = DEF_SHEET_W,
   parameter int TILE           = DEF_TILE,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int PIX_W          = DEF_PIX_W,
   parameter int NUM_SPR        = DEF_NUM_SPR,
   parameter int PAL_DEPTH      = DEF_PAL_DEPTH,
   parameter int TRANSPARENT_ID = DEF_TRANSPARENT_ID,
   parameter int COLOR_W        = DEF_COLOR_W,
   parameter int ORIGIN_X       = DEF_ORIGIN_X,
   parameter int ORIGIN_Y       = DEF_ORIGIN_Y
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         pix_valid,
   input  logic [9:0]                   DrawX,
   input  logic [9:0]                   DrawY,
   input  logic [NUM_SPR-1:0]           spr_hit,
   input  logic [NUM_SPR-1:0][9:0]      spr_x,
   input  logic [NUM_SPR-1:0][9:0]      spr_y,
   input  logic [NUM_SPR-1:0][2:0]      spr_tile_x,
   input  logic [NUM_SPR-1:0][2:0]      spr_tile_y,
   input  logic [NUM_SPR-1:0]           spr_flip,
   input  logic [2:0]                   bg_tile_x,
   input  logic [2:0]                   bg_tile_y,
   output logic [ADDR_W-1:0]            rom_addr_spr,
   output logic [ADDR_W-1:0]            rom_addr_bg,
   input  logic [PIX_W-1:0]             rom_data_spr,
   input  logic [PIX_W-1:0]             rom_data_bg,
   input  logic                         pal_we,
   input  logic [PIX_W-1:0]             pal_waddr,
   input  logic [3*COLOR_W-1:0]         pal_wdata,
   output logic                         out_valid,
   output logic [COLOR_W-1:0]           VGA_R,
   output logic [COLOR_W-1:0]           VGA_G,
   output logic [COLOR_W-1:0]           VGA_B
);
   localparam logic [3*COLOR_W-1:0] SKY_C = {COLOR_W'(SKY.r), COLOR_W'(SKY.g), COLOR_W'(SKY.b)};
   // Magenta channels are all-ones or all-zeros, so replicating the MSB scales to any COLOR_W
   localparam logic [3*COLOR_W-1:0] MAG_C = {{COLOR_W{MAGENTA.r[7]}}, {COLOR_W{MAGENTA.g[7]}},
                                             {COLOR_W{MAGENTA.b[7]}}};
   logic [9:0]           sx, sy;
   logic [2:0]           tx, ty;
   logic                 fl;
   logic [15:0]          rx_bg, ry_bg, rx_spr, ry_spr;
   logic [ADDR_W-1:0]    addr_spr, addr_bg;
   logic                 hit_a, valid_a, hit_b, valid_b;
   logic [PIX_W-1:0]     idx;
   logic [3*COLOR_W-1:0] pal_rd;
   logic [3*COLOR_W-1:0] pal [PAL_DEPTH];
   // Descending scan so the lowest-numbered hit layer is the one left selected
   always_comb begin
      sx = spr_x[0];
      sy = spr_y[0];
      tx = spr_tile_x[0];
      ty = spr_tile_y[0];
      fl = spr_flip[0];
      for (int i = NUM_SPR - 1; i >= 0; i--)
         if (spr_hit[i]) begin
            sx = spr_x[i];
            sy = spr_y[i];
            tx = spr_tile_x[i];
            ty = spr_tile_y[i];
            fl = spr_flip[i];
         end
   end
   assign rx_bg  = 16'(DrawX) - 16'(ORIGIN_X);
   assign ry_bg  = 16'(DrawY) - 16'(ORIGIN_Y);
   assign rx_spr = rx_bg - 16'(sx);
   assign ry_spr = ry_bg - 16'(sy);
   sprite_addr_gen #(.SHEET_W(SHEET_W), .TILE(TILE), .ADDR_W(ADDR_W)) u_spr (
      .rx(rx_spr), .ry(ry_spr), .tile_x(tx), .tile_y(ty), .flip(fl), .addr(addr_spr)
   );
   sprite_addr_gen #(.SHEET_W(SHEET_W), .TILE(TILE), .ADDR_W(ADDR_W)) u_bg (
      .rx(rx_bg), .ry(ry_bg), .tile_x(bg_tile_x), .tile_y(bg_tile_y), .flip(1'b0), .addr(addr_bg)
   );
   // ROM output registers act as stage B; hit/valid are delayed to line up with them
   assign idx = (hit_b && rom_data_spr != PIX_W'(TRANSPARENT_ID)) ? rom_data_spr : rom_data_bg;
   always_comb begin
      pal_rd = MAG_C;
      for (int i = 0; i < PAL_DEPTH; i++)
         if (idx == PIX_W'(i)) pal_rd = pal[i];
   end
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         rom_addr_spr <= '0;
         rom_addr_bg  <= '0;
         hit_a        <= 1'b0;
         valid_a      <= 1'b0;
         hit_b        <= 1'b0;
         valid_b      <= 1'b0;
         out_valid    <= 1'b0;
         {VGA_R, VGA_G, VGA_B} <= '0;
      end else begin
         rom_addr_spr <= addr_spr;
         rom_addr_bg  <= addr_bg;
         hit_a        <= |spr_hit;
         valid_a      <= pix_valid;
         hit_b        <= hit_a;
         valid_b      <= valid_a;
         out_valid    <= valid_b;
         {VGA_R, VGA_G, VGA_B} <= valid_b ? pal_rd : '0;
      end
   // Flop palette: a same-cycle read sees the value before this edge's write
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n)
         for (int i = 0; i < PAL_DEPTH; i++) pal[i] <= (i == 0) ? SKY_C : MAG_C;
      else if (pal_we)
         for (int i = 0; i < PAL_DEPTH; i++)
            if (pal_waddr == PIX_W'(i)) pal[i] <= pal_wdata;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed checks of addressing, priority, palette and reset
module tb_sprite_compositor;
   logic            Clk = 1'b0, Reset_n = 1'b1, pix_valid = 1'b0;
   logic [9:0]      DrawX = '0, DrawY = '0;
   logic [1:0]      spr_hit = '0, spr_flip = '0;
   logic [1:0][9:0] spr_x = '0, spr_y = '0;
   logic [1:0][2:0] spr_tile_x = '0, spr_tile_y = '0;
   logic [2:0]      bg_tile_x = '0, bg_tile_y = '0;
   logic [15:0]     rom_addr_spr, rom_addr_bg;
   logic [3:0]      rom_data_spr = '0, rom_data_bg = '0;
   logic            pal_we = 1'b0;
   logic [3:0]      pal_waddr = '0;
   logic [23:0]     pal_wdata = '0;
   logic            out_valid;
   logic [7:0]      VGA_R, VGA_G, VGA_B;
   logic [3:0]      spr_rom [65536];
   logic [3:0]      bg_rom  [65536];
   int checks = 0, errors = 0;
   sprite_compositor #(.PAL_DEPTH(12)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
      .spr_hit(spr_hit), .spr_x(spr_x), .spr_y(spr_y), .spr_tile_x(spr_tile_x),
      .spr_tile_y(spr_tile_y), .spr_flip(spr_flip), .bg_tile_x(bg_tile_x), .bg_tile_y(bg_tile_y),
      .rom_addr_spr(rom_addr_spr), .rom_addr_bg(rom_addr_bg), .rom_data_spr(rom_data_spr),
      .rom_data_bg(rom_data_bg), .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
      .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );
   always #5 Clk = ~Clk;
   always @(posedge Clk) begin
      rom_data_spr <= spr_rom[rom_addr_spr];
      rom_data_bg  <= bg_rom[rom_addr_bg];
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask
   task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
      pal_we = 1'b1;
      pal_waddr = a;
      pal_wdata = d;
      cyc();
      pal_we = 1'b0;
   endtask
   task automatic pixel(input string tag, input logic [15:0] es, input logic [15:0] eb,
                        input logic [23:0] rgb);
      pix_valid = 1'b1;
      cyc();
      pix_valid = 1'b0;
      check({tag, " spr_addr"}, 32'(rom_addr_spr), 32'(es));
      check({tag, " bg_addr"}, 32'(rom_addr_bg), 32'(eb));
      cyc();
      check({tag, " early_valid"}, 32'(out_valid), 32'd0);
      cyc();
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'(rgb));
   endtask
   initial begin
      for (int i = 0; i < 65536; i++) begin
         spr_rom[i] = '0;
         bg_rom[i]  = '0;
      end
      #3 Reset_n = 1'b0;
      pix_valid = 1'b1;
      DrawX = 10'd120;
      DrawY = 10'd40;
      bg_tile_x = 3'd4;
      bg_tile_y = 3'd4;
      repeat (3) cyc();
      check("rst valid", 32'(out_valid), 32'd0);
      check("rst rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      check("rst spr_addr", 32'(rom_addr_spr), 32'd0);
      check("rst bg_addr", 32'(rom_addr_bg), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      pix_valid = 1'b0;
      cyc();
      cyc();
      check("idle valid", 32'(out_valid), 32'd0);
      pixel("bg_only", 16'd0, 16'd32160, 24'h0AB1FF);
      pal_write(4'd3, 24'h303030);
      pal_write(4'd5, 24'h505050);
      pal_write(4'd11, 24'hB0B0B0);
      spr_hit = 2'b11;
      spr_tile_x[0] = 3'd1;
      spr_tile_x[1] = 3'd2;
      bg_tile_x = 3'd0;
      bg_tile_y = 3'd0;
      DrawX = 10'd125;
      DrawY = 10'd42;
      spr_rom[445] = 4'd5;
      bg_rom[405]  = 4'd3;
      pixel("priority", 16'd445, 16'd405, 24'h505050);
      spr_hit = 2'b10;
      pixel("transparent", 16'd485, 16'd405, 24'h303030);
      spr_hit = 2'b01;
      spr_tile_x = '0;
      spr_flip = 2'b01;
      DrawX = 10'd120;
      DrawY = 10'd40;
      spr_rom[39] = 4'd5;
      pixel("flip", 16'd39, 16'd0, 24'h505050);
      spr_flip = 2'b00;
      pixel("noflip", 16'd0, 16'd0, 24'h0AB1FF);
      spr_flip = 2'b01;
      spr_x[0] = 10'd3;
      spr_y[0] = 10'd1;
      spr_tile_x[0] = 3'd1;
      spr_tile_y[0] = 3'd1;
      DrawX = 10'd130;
      DrawY = 10'd45;
      spr_rom[8872] = 4'd3;
      pixel("offset_flip", 16'd8872, 16'd1010, 24'h303030);
      spr_hit = 2'b00;
      spr_flip = 2'b00;
      spr_x = '0;
      spr_y = '0;
      spr_tile_x = '0;
      spr_tile_y = '0;
      DrawX = 10'd0;
      DrawY = 10'd0;
      bg_rom[3216] = 4'd5;
      pixel("wrap", 16'd3216, 16'd3216, 24'h505050);
      DrawX = 10'd120;
      DrawY = 10'd40;
      bg_tile_x = 3'd2;
      bg_rom[80] = 4'd11;
      pixel("last_entry", 16'd0, 16'd80, 24'hB0B0B0);
      bg_tile_x = 3'd0;
      bg_tile_y = 3'd1;
      bg_rom[8000] = 4'd12;
      pixel("idx_depth", 16'd0, 16'd8000, 24'hFF00FF);
      bg_tile_x = 3'd1;
      bg_tile_y = 3'd0;
      bg_rom[40] = 4'd15;
      pixel("idx_15", 16'd0, 16'd40, 24'hFF00FF);
      bg_tile_x = 3'd3;
      bg_rom[120] = 4'd2;
      pix_valid = 1'b1;
      cyc();
      cyc();
      pix_valid = 1'b0;
      pal_we = 1'b1;
      pal_waddr = 4'd2;
      pal_wdata = 24'h112233;
      cyc();
      pal_we = 1'b0;
      check("hazard old valid", 32'(out_valid), 32'd1);
      check("hazard old rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'hFF00FF);
      cyc();
      check("hazard new valid", 32'(out_valid), 32'd1);
      check("hazard new rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h112233);
      cyc();
      check("hazard end valid", 32'(out_valid), 32'd0);
      pix_valid = 1'b1;
      cyc();
      cyc();
      Reset_n = 1'b0;
      #1;
      check("midrst valid", 32'(out_valid), 32'd0);
      check("midrst bg_addr", 32'(rom_addr_bg), 32'd0);
      check("midrst rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      cyc();
      Reset_n = 1'b1;
      pix_valid = 1'b0;
      pal_we = 1'b1;
      pal_waddr = 4'd4;
      pal_wdata = 24'h445566;
      cyc();
      pal_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("flushed valid", 32'(out_valid), 32'd0);
         cyc();
      end
      bg_tile_x = 3'd4;
      bg_rom[160] = 4'd4;
      pixel("write_at_release", 16'd0, 16'd160, 24'h445566);
      bg_tile_x = 3'd0;
      DrawX = 10'd125;
      DrawY = 10'd42;
      pixel("pal_reset", 16'd405, 16'd405, 24'hFF00FF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised, pipelined pixel colour engine that replaces the single-layer colour mapper in the VGA path. Each cycle it takes one pixel coordinate from the VGA controller, resolves up to NUM_SPR prioritised sprite layers over a background tile, and fetches sprite-sheet indices from an external synchronous ROM. It composites with a transparent index, maps the result through a CPU-writable palette, and emits registered RGB with a matching valid flag.

## Interface
- SHEET_W, 200: sprite-sheet width in pixels.
- TILE, 40: tile/sprite edge in pixels.
- ADDR_W, 16: ROM address width.
- PIX_W, 4: palette index width.
- NUM_SPR, 2: sprite layers; layer 0 has highest priority.
- PAL_DEPTH, 16: palette entries; must be ≤ 2**PIX_W.
- TRANSPARENT_ID, 0: sprite index treated as see-through.
- COLOR_W, 8: per-channel colour width.
- ORIGIN_X, 120 / ORIGIN_Y, 40: playfield origin in screen pixels.
- Clk  in  1  single clock.
- Reset_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  DrawX/DrawY valid (active video).
- DrawX, DrawY  in  10 each  current screen pixel.
- spr_hit  in  NUM_SPR  per-layer "pixel inside sprite".
- spr_x, spr_y  in  NUM_SPR×10  sprite top-left, playfield-relative.
- spr_tile_x, spr_tile_y  in  NUM_SPR×3  sheet tile column/row.
- spr_flip  in  NUM_SPR  horizontal mirror per layer.
- bg_tile_x, bg_tile_y  in  3 each  background tile for this pixel.
- rom_addr_spr, rom_addr_bg  out  ADDR_W  ROM read addresses.
- rom_data_spr, rom_data_bg  in  PIX_W  ROM data, 1-cycle latency.
- pal_we  in  1; pal_waddr  in  PIX_W; pal_wdata  in  3×COLOR_W ({R,G,B})  palette write port.
- out_valid  out  1; VGA_R, VGA_G, VGA_B  out  COLOR_W each.

## Operation
- Stage A (register at edge 1): priority-encode spr_hit; the lowest set index is the winning layer w. Compute px = DrawX−ORIGIN_X−spr_x[w], py = DrawY−ORIGIN_Y−spr_y[w], all 16-bit unsigned modulo arithmetic. If spr_flip[w], px' = TILE−1−(px mod TILE), else px' = px mod TILE.
- Sprite address = SHEET_W·TILE·tile_y + TILE·tile_x + px' + (py mod TILE)·SHEET_W, truncated to ADDR_W.
- Background address uses the same formula with bg_tile and the playfield-relative coordinates, with no flip.
- The stage registers the addresses, a hit flag (any spr_hit) and the valid flag.
- Stage B (ROM returns at edge 2): data registered alongside the delayed hit/valid flags.
- Stage C: idx = (hit && rom_data_spr ≠ TRANSPARENT_ID) ? rom_data_spr : rom_data_bg. The palette read is registered into VGA_R/G/B at edge 3.
- Index ≥ PAL_DEPTH outputs magenta (all-ones R, 0 G, all-ones B).
- If the delayed valid flag is 0: RGB forced to 0, out_valid = 0.
- Palette: flop array. A write takes effect at the clock edge. A read of the same entry in the same cycle returns the old value; the new value is seen from the next cycle.

## Timing
- Latency is fixed at 3 cycles from pix_valid/DrawX sampled → out_valid/RGB.
- Throughput is 1 pixel/cycle, with no stalls and no backpressure.
- Reset (asynchronous assert, synchronous release):
  - all pipeline valids, rom_addr_* and RGB go to 0.
  - palette[0] = 0x0A,0xB1,0xFF (sky).
  - entries 1..PAL_DEPTH−1 = magenta.
- Reset asserted mid-frame flushes all in-flight pixels. out_valid stays 0 until 3 cycles after the first valid pixel following release.
- Palette writes are accepted during reset release, from the first edge with Reset_n high.

## Structure
- Package sprite_pkg:
  - rgb_t struct {r,g,b}.
  - SKY and MAGENTA constants.
  - shared default parameter values.
- Sub-module sprite_addr_gen computes one address from coords/position/tile/flip. Two instances: winning sprite and background.
- Palette flops, priority encoder and pipeline live in the top.

## Test plan
- Reset: hold Reset_n=0 while pix_valid=1. Required: out_valid=0, RGB=0, rom_addr_*=0. After release, a pixel with idx 0 yields 0A/B1/FF exactly 3 cycles later.
- Background only: DrawX=120, DrawY=40, spr_hit=0, bg tile (4,4). Required: rom_addr_bg=32160 at edge 1. With rom_data_bg=0, sky is output at edge 3.
- Priority: spr_hit=2'b11. Layer 0 at (0,0) tile (1,0); layer 1 at (0,0) tile (2,0); DrawX=125, DrawY=42. Required: rom_addr_spr = 40+5+2·200 = 445.
- Transparency: sprite hit with rom_data_spr=0 and rom_data_bg=3. Required: palette[3] output. With rom_data_spr=5, palette[5] is output.
- Flip: layer 0 flip=1, spr_x=0, tile (0,0), DrawX=120, DrawY=40. Required: rom_addr_spr=39. With flip=0 the address is 0.
- Palette hazard: write entry 2 = 11/22/33 in the same cycle its read occurs. Required: old value that cycle, 11/22/33 on the next read. Index 15 with PAL_DEPTH=12 outputs magenta.
